// File: rtl/strait_bist_pkg.sv
// Shared definitions for the STRAIT MAC BIST pattern generator.
//   - bist_state_e   : sequencing FSM states
//   - LFSR_TAPS      : Galois right-shift tap mask for the 16-bit LFSRs
//   - CB_PAT_55/AA   : checkerboard operand patterns (sliced to DATA_W)
//   - DEFAULT_SEED_* : default LFSR start values
//   - lfsr16_step    : one Galois step of a 16-bit LFSR
package strait_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] CB_PAT_55      = 16'h5555;
  localparam logic [15:0] CB_PAT_AA      = 16'hAAAA;
  localparam logic [15:0] DEFAULT_SEED_A = 16'hACE1;
  localparam logic [15:0] DEFAULT_SEED_B = 16'h1D2C;

  function automatic logic [15:0] lfsr16_step(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/strait_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load and step enable.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-low reset (state <= SEED)
//   load  in   reload SEED (has priority over en)
//   en    in   advance one Galois step
//   q     out  low OUT_W bits of the LFSR state
module strait_lfsr16
  import strait_bist_pkg::*;
#(
  parameter int unsigned OUT_W = 16,
  parameter logic [15:0] SEED  = DEFAULT_SEED_A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [OUT_W-1:0] q
);

  logic [15:0] state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (en) begin
      state <= lfsr16_step(state);
    end
  end

  assign q = state[OUT_W-1:0];

endmodule

// File: rtl/strait_bist_pattern_gen.sv
// STRAIT MAC BIST stimulus and golden-model stage.
// Issues NUM_VECTORS pseudo-random operand pairs to the MAC under test,
// keeps a golden running sum and presents it on `expected`, delayed so it
// lines up with the MAC's accum_out. Sequenced by start/busy/done.
// Optional: define STRAIT_CHECKERBOARD_EN to add `pattern_sel`, selecting a
// 0x55/0xAA checkerboard operand stream instead of the LFSRs.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   start       in   run request, honoured only in IDLE
//   pattern_sel in   (STRAIT_CHECKERBOARD_EN only) checkerboard mode, sampled at start
//   a_out       out  operand A
//   b_out       out  operand B
//   valid_out   out  operands valid this cycle
//   acc_clr     out  one-cycle MAC accumulator clear
//   expected    out  golden sum aligned to accum_out
//   cmp_en      out  expected is meaningful
//   busy        out  high outside IDLE
//   done        out  one-cycle end-of-run pulse
module strait_bist_pattern_gen
  import strait_bist_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned MAC_LAT     = 2,
  parameter logic [15:0] SEED_A      = DEFAULT_SEED_A,
  parameter logic [15:0] SEED_B      = DEFAULT_SEED_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef STRAIT_CHECKERBOARD_EN
  input  logic              pattern_sel,
`endif
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic              acc_clr,
  output logic [ACC_W-1:0]  expected,
  output logic              cmp_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_MAX = (NUM_VECTORS > MAC_LAT) ? NUM_VECTORS : MAC_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PROD_W  = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_VEC   = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(MAC_LAT - 1);

  bist_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic              launch;
  logic              cb_mode;
  logic              lfsr_en;
  logic [DATA_W-1:0] lfsr_a;
  logic [DATA_W-1:0] lfsr_b;
  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] b_next;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  sum_in;
  logic [ACC_W-1:0]  sum_line [MAC_LAT];
  logic              vld_line [MAC_LAT];

  assign launch = (state == ST_IDLE) && start;

`ifdef STRAIT_CHECKERBOARD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cb_mode <= 1'b0;
    end else if (launch) begin
      cb_mode <= pattern_sel;
    end
  end
`else
  assign cb_mode = 1'b0;
`endif

  // LFSRs are reloaded on the start edge so they hold the seeds during
  // CLEAR; the CLEAR->RUN edge then issues the seed as the first vector.
  assign lfsr_en = !cb_mode &&
                   ((state == ST_CLEAR) || ((state == ST_RUN) && (cnt != LAST_VEC)));

  strait_lfsr16 #(.OUT_W(DATA_W), .SEED(SEED_A)) u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (launch),
    .en   (lfsr_en),
    .q    (lfsr_a)
  );

  strait_lfsr16 #(.OUT_W(DATA_W), .SEED(SEED_B)) u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (launch),
    .en   (lfsr_en),
    .q    (lfsr_b)
  );

  always_comb begin
    a_next = lfsr_a;
    b_next = lfsr_b;
`ifdef STRAIT_CHECKERBOARD_EN
    if (cb_mode) begin
      if ((state == ST_CLEAR) || (a_out != CB_PAT_55[DATA_W-1:0])) begin
        a_next = CB_PAT_55[DATA_W-1:0];
      end else begin
        a_next = CB_PAT_AA[DATA_W-1:0];
      end
      b_next = ~a_next;
    end
`endif
  end

  assign prod   = PROD_W'(a_out) * PROD_W'(b_out);
  assign sum_in = valid_out ? (sum + ACC_W'(prod)) : sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
      acc_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
    end else begin
      acc_clr <= 1'b0;
      done    <= 1'b0;
      sum     <= sum_in;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_CLEAR;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
            sum     <= '0;
          end
        end
        ST_CLEAR: begin
          state     <= ST_RUN;
          cnt       <= '0;
          sum       <= '0;
          valid_out <= 1'b1;
          a_out     <= a_next;
          b_out     <= b_next;
        end
        ST_RUN: begin
          if (cnt == LAST_VEC) begin
            state     <= ST_DRAIN;
            cnt       <= '0;
            valid_out <= 1'b0;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            a_out <= a_next;
            b_out <= b_next;
          end
        end
        ST_DRAIN: begin
          if (cnt == LAST_DRAIN) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stage 0 captures the post-accumulate sum in the issue cycle, so the
  // last stage shows it MAC_LAT cycles after valid_out. Outside a run the
  // sum is constant, so expected naturally holds its final value in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MAC_LAT; i++) begin
        sum_line[i] <= '0;
        vld_line[i] <= 1'b0;
      end
    end else if (launch || (state == ST_CLEAR)) begin
      for (int unsigned i = 0; i < MAC_LAT; i++) begin
        sum_line[i] <= '0;
        vld_line[i] <= 1'b0;
      end
    end else begin
      sum_line[0] <= sum_in;
      vld_line[0] <= valid_out;
      for (int unsigned i = 1; i < MAC_LAT; i++) begin
        sum_line[i] <= sum_line[i-1];
        vld_line[i] <= vld_line[i-1];
      end
    end
  end

  assign expected = sum_line[MAC_LAT-1];
  assign cmp_en   = vld_line[MAC_LAT-1];

endmodule

// File: tb/tb_strait_bist_pattern_gen.sv
// Self-checking bench for strait_bist_pattern_gen: scoreboard of operand
// pairs and golden sums, cycle schedule of the handshake outputs, mid-run
// reset, back-to-back runs and accumulator wrap on a second instance.
module tb_strait_bist_pattern_gen;

  localparam int NV = 4;
  localparam int ML = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [7:0]  a_out, b_out;
  logic        valid_out, acc_clr, cmp_en, busy, done;
  logic [31:0] expected;
`ifdef STRAIT_CHECKERBOARD_EN
  logic        pattern_sel;
`endif

  logic        w_rst, w_start;
  logic [7:0]  w_a, w_b;
  logic        w_valid, w_acc_clr, w_cmp_en, w_busy, w_done;
  logic [15:0] w_expected;

  strait_bist_pattern_gen #(
    .DATA_W(8), .ACC_W(32), .NUM_VECTORS(NV), .MAC_LAT(ML),
    .SEED_A(16'hACE1), .SEED_B(16'h1D2C)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef STRAIT_CHECKERBOARD_EN
    .pattern_sel(pattern_sel),
`endif
    .a_out(a_out), .b_out(b_out), .valid_out(valid_out), .acc_clr(acc_clr),
    .expected(expected), .cmp_en(cmp_en), .busy(busy), .done(done)
  );

  // Seed 0x01FF keeps the low byte at 0xFF for two consecutive steps.
  strait_bist_pattern_gen #(
    .DATA_W(8), .ACC_W(16), .NUM_VECTORS(2), .MAC_LAT(2),
    .SEED_A(16'h01FF), .SEED_B(16'h01FF)
  ) wdut (
    .clk(clk), .rst(w_rst), .start(w_start),
`ifdef STRAIT_CHECKERBOARD_EN
    .pattern_sel(1'b0),
`endif
    .a_out(w_a), .b_out(w_b), .valid_out(w_valid), .acc_clr(w_acc_clr),
    .expected(w_expected), .cmp_en(w_cmp_en), .busy(w_busy), .done(w_done)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int w_done_cnt = 0;
  int runs_done = 0;

  logic [15:0] op_q [$];
  logic [31:0] sum_q [$];
  logic [15:0] w_q [$];
  logic [15:0] mon_op;
  logic [31:0] mon_sum;
  logic [15:0] mon_w;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic build_run(input bit cb, output logic [31:0] final_sum);
    logic [15:0] la, lb;
    logic [7:0]  av, bv;
    logic [31:0] s;
    la = 16'hACE1;
    lb = 16'h1D2C;
    s  = '0;
    for (int i = 0; i < NV; i++) begin
      if (cb) begin
        av = (i % 2 == 0) ? 8'h55 : 8'hAA;
        bv = ~av;
      end else begin
        av = la[7:0];
        bv = lb[7:0];
        la = model_step(la);
        lb = model_step(lb);
      end
      op_q.push_back({av, bv});
      s = s + (32'(av) * 32'(bv));
      sum_q.push_back(s);
    end
    final_sum = s;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (valid_out) begin
        if (op_q.size() == 0) check_val("op_unexpected", 64'(1), 64'(0));
        else begin
          mon_op = op_q.pop_front();
          check_val("operands", 64'({a_out, b_out}), 64'(mon_op));
        end
      end
      if (cmp_en) begin
        if (sum_q.size() == 0) check_val("exp_unexpected", 64'(1), 64'(0));
        else begin
          mon_sum = sum_q.pop_front();
          check_val("expected", 64'(expected), 64'(mon_sum));
        end
      end
      if (done) done_cnt++;
    end
    if (w_rst) begin
      if (w_valid) check_val("wrap_operands", 64'({w_a, w_b}), 64'(16'hFFFF));
      if (w_cmp_en) begin
        if (w_q.size() == 0) check_val("wrap_unexpected", 64'(1), 64'(0));
        else begin
          mon_w = w_q.pop_front();
          check_val("wrap_expected", 64'(w_expected), 64'(mon_w));
        end
      end
      if (w_done) w_done_cnt++;
    end
  end

  // Called at a negedge; drives start there and ends at the negedge of the
  // first IDLE cycle after done (k=9).
  task automatic run_once(input bit cb, input bit poke_busy, input bit poke_done,
                          output logic [31:0] fs);
    build_run(cb, fs);
`ifdef STRAIT_CHECKERBOARD_EN
    pattern_sel = cb;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      check_val($sformatf("sched_k%0d", k), 64'({acc_clr, valid_out, cmp_en, busy, done}),
                64'({k == 1, (k >= 2) && (k <= 5), (k >= 4) && (k <= 7),
                     (k >= 1) && (k <= 8), k == 8}));
      if (k == 1) check_val("exp_clear", 64'(expected), 64'(0));
      if (k == 2 && !cb) check_val("first_pair", 64'({a_out, b_out}), 64'(16'hE12C));
      if (k == 4 && !cb) check_val("first_exp", 64'(expected), 64'(32'h000026AC));
      if (k == 9) check_val("exp_hold", 64'(expected), 64'(fs));
      if (poke_busy && k == 3) start = 1'b1;
      if (poke_busy && k == 4) start = 1'b0;
      if (poke_done && k == 8) start = 1'b1;
      if (k == 9) start = 1'b0;
      if (k < 9) @(negedge clk);
    end
    check_val("op_q_drained", 64'(op_q.size()), 64'(0));
    check_val("sum_q_drained", 64'(sum_q.size()), 64'(0));
    runs_done++;
  endtask

  logic [31:0] fs;
  int d0;

  initial begin
    rst = 1'b0; start = 1'b0; w_rst = 1'b0; w_start = 1'b0;
`ifdef STRAIT_CHECKERBOARD_EN
    pattern_sel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_val("reset_outs", 64'({a_out, b_out, valid_out, acc_clr, expected, cmp_en, busy, done}), 64'(0));
    rst = 1'b1; w_rst = 1'b1;
    @(negedge clk);

    run_once(1'b0, 1'b0, 1'b0, fs);
    // back-to-back: start in the first IDLE cycle after done
    run_once(1'b0, 1'b0, 1'b0, fs);
    // start while busy and in the DONE cycle
    run_once(1'b0, 1'b1, 1'b1, fs);
    repeat (2) begin
      @(negedge clk);
      check_val("no_reload", 64'({busy, acc_clr, valid_out}), 64'(0));
      check_val("idle_hold", 64'(expected), 64'(fs));
    end
    check_val("done_count_a", 64'(done_cnt), 64'(runs_done));

    // mid-run reset during vector 3
    build_run(1'b0, fs);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_val("abort_outs", 64'({a_out, b_out, valid_out, acc_clr, expected, cmp_en, busy, done}), 64'(0));
    op_q.delete();
    sum_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    check_val("abort_no_done", 64'(done_cnt), 64'(d0));
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_idle", 64'(busy), 64'(0));
    run_once(1'b0, 1'b0, 1'b0, fs);

`ifdef STRAIT_CHECKERBOARD_EN
    @(negedge clk);
    run_once(1'b1, 1'b0, 1'b0, fs);
    @(negedge clk);
    check_val("cb_final", 64'(expected), 64'(32'h0000E1C8));
`endif
    check_val("done_count", 64'(done_cnt), 64'(runs_done));

    // accumulator wrap on the ACC_W=16 instance
    w_q.push_back(16'hFE01);
    w_q.push_back(16'hFC02);
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    repeat (8) @(negedge clk);
    check_val("wrap_drained", 64'(w_q.size()), 64'(0));
    check_val("wrap_hold", 64'(w_expected), 64'(16'hFC02));
    check_val("wrap_done", 64'(w_done_cnt), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/strait_bist_pattern_gen.md
Name: strait_bist_pattern_gen

Overview:
- Upstream stimulus and golden-model stage of the STRAIT MAC BIST.
- Drives pseudo-random operand pairs into the MAC/accumulator under test.
- Computes the golden running sum in parallel and presents it as `expected`, latency-aligned with the MAC's `accum_out`, to the main comparator.
- Sequences the test with a start/busy/done handshake.

Parameters:
- DATA_W, 8, operand width (max 16).
- ACC_W, 32, accumulator/expected width.
- NUM_VECTORS, 256, operand pairs per run (>=1).
- MAC_LAT, 2, cycles from valid_out to accum_out reflecting that operand (>=1).
- SEED_A, 16'hACE1, LFSR A reset/start value (nonzero).
- SEED_B, 16'h1D2C, LFSR B reset/start value (nonzero).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- a_out  out  DATA_W  operand A to MAC.
- b_out  out  DATA_W  operand B to MAC.
- valid_out  out  1  operands valid; MAC accumulates this cycle.
- acc_clr  out  1  one-cycle clear to MAC accumulator.
- expected  out  ACC_W  golden sum aligned to accum_out.
- cmp_en  out  1  expected is meaningful (valid_out delayed MAC_LAT).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE.
  - All outputs 0.
  - LFSR A = SEED_A, LFSR B = SEED_B.
  - Golden sum and delay line cleared.
  - Applies mid-run too: the run is aborted with no done pulse.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> CLEAR.
  - expected holds its last value so the comparator stays quiet after a run.
- CLEAR (1 cycle):
  - acc_clr=1.
  - LFSRs reloaded to seeds.
  - Golden sum, delay line and expected set to 0.
  - Vector counter set to 0.
  - -> RUN.
- RUN (NUM_VECTORS cycles):
  - valid_out=1.
  - a_out = LFSR A[DATA_W-1:0], b_out = LFSR B[DATA_W-1:0].
  - Golden sum += a_out*b_out, modulo 2^ACC_W (product zero-extended, wrap silently).
  - Both LFSRs advance, Galois right shift: next = {0, L[15:1]} ^ (L[0] ? 16'hB400 : 0).
  - After the last vector -> DRAIN.
- DRAIN (MAC_LAT cycles):
  - valid_out=0, operands held.
  - Delay line flushes.
  - -> DONE.
- DONE (1 cycle):
  - done=1, then -> IDLE.
- Alignment:
  - expected(t) = golden sum after the vector issued at t-MAC_LAT.
  - Implemented as a MAC_LAT-deep register line on {sum, valid}.
  - cmp_en = valid_out delayed by MAC_LAT.
- Handshake:
  - start while busy is ignored.
  - start asserted in the same cycle as DONE is ignored; it must be reasserted in IDLE.
- Timing: the first valid_out is 2 cycles after the start sample; done is at 1+1+NUM_VECTORS+MAC_LAT cycles after start.

Optional Feature:
- Macro: STRAIT_CHECKERBOARD_EN.
- Defined:
  - Adds input `pattern_sel` (1 bit), sampled at start.
  - When sampled high, RUN issues a_out alternating 0x55-pattern / 0xAA-pattern (replicated to DATA_W, first vector 0x55…), with b_out = ~a_out.
  - LFSRs are not advanced; golden arithmetic is unchanged.
- Undefined: port absent; LFSR operands only.

Decomposition:
- Package strait_bist_pkg holds:
  - FSM state enum.
  - LFSR taps constant 16'hB400.
  - Checkerboard constants.
  - Default seed constants.
- One natural sub-module: strait_lfsr16 (seed load, enable, Galois step), instantiated twice.

Test Plan:
- Reset mid-RUN:
  - Stimulus: rst low at vector 3.
  - Required: all outputs 0 asynchronously; state IDLE; no done pulse; next start reproduces the full sequence from the seeds.
- LFSR run, NUM_VECTORS=4, MAC_LAT=2, DATA_W=8:
  - Stimulus: start at cycle 0.
  - Required: acc_clr at cycle 1; valid_out cycles 2–5; first pair a=0xE1, b=0x2C; expected=0x000026AC with cmp_en=1 at cycle 4; done at cycle 8; busy cycles 1–8.
- Checkerboard, macro defined, pattern_sel=1, NUM_VECTORS=4:
  - Stimulus: single run.
  - Required: pairs (0x55,0xAA),(0xAA,0x55)…; final expected=0x0000E1C8 held after done.
- Wrap-around, ACC_W=16, operands forced 0xFF:
  - Stimulus: 2 vectors.
  - Required: expected = 0xFE01 then 0xFC02 (wrapped), no error indication.
- start during busy and concurrent with DONE:
  - Required: both ignored; exactly one done pulse; no reload.
- Back-to-back runs:
  - Stimulus: start in the first IDLE cycle after done.
  - Required: expected cleared to 0 in CLEAR; identical sequence and final sum as the first run.
